// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: collects NUM_DIGITS active-low 7-segment patterns into
// a packed hex value. The first digit of a frame lands in the top nibble, and
// each illegal pattern is flagged in err_mask. A frame_start in mid-frame
// restarts collection and pulses sync_err for one cycle.
module seg_frame_decoder #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic                    frame_start,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    sync_err
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [4*NUM_DIGITS-1:0]   value_q, value_d;
  logic [NUM_DIGITS-1:0]     err_q, err_d;
  logic                      sync_err_q, sync_err_d;
  logic                      seg_ready_q;
  logic                      value_valid_q;
  logic                      xfer_s;
  logic [3:0]                dec_nib_s;
  logic                      dec_err_s;
  logic [NUM_DIGITS-1:0]     pos_err_s;

  // Map an active-low segment pattern to {illegal, nibble}; unknown -> {1, 0}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b0, 4'h0};
      7'h79:   res = {1'b0, 4'h1};
      7'h24:   res = {1'b0, 4'h2};
      7'h30:   res = {1'b0, 4'h3};
      7'h19:   res = {1'b0, 4'h4};
      7'h12:   res = {1'b0, 4'h5};
      7'h02:   res = {1'b0, 4'h6};
      7'h78:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h10:   res = {1'b0, 4'h9};
      7'h08:   res = {1'b0, 4'hA};
      7'h03:   res = {1'b0, 4'hB};
      7'h46:   res = {1'b0, 4'hC};
      7'h21:   res = {1'b0, 4'hD};
      7'h06:   res = {1'b0, 4'hE};
      7'h0E:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  assign {dec_err_s, dec_nib_s} = seg_decode(seg_in);
  assign xfer_s = seg_valid & seg_ready_q;

  // One-hot error bit for the digit position about to be stored.
  always_comb begin
    pos_err_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pos_err_s[i] = dec_err_s & (count_q == CNT_W'(i));
    end
  end

  // Next-state and datapath: start, shift-in, resync and frame hand-off.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    value_d    = value_q;
    err_d      = err_q;
    sync_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_s && frame_start) begin
          value_d      = '0;
          value_d[3:0] = dec_nib_s;
          err_d        = '0;
          err_d[0]     = dec_err_s;
          count_d      = CNT_ONE;
          state_d      = (NUM_DIGITS == 1) ? DONE : COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (xfer_s && frame_start) begin
          // Early frame_start: drop the partial frame and restart on this digit.
          value_d      = '0;
          value_d[3:0] = dec_nib_s;
          err_d        = '0;
          err_d[0]     = dec_err_s;
          count_d      = CNT_ONE;
          sync_err_d   = 1'b1;
          state_d      = COLLECT;
        end else if (xfer_s) begin
          value_d      = value_q << 4;
          value_d[3:0] = dec_nib_s;
          err_d        = err_q | pos_err_s;
          count_d      = count_q + CNT_ONE;
          if (count_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        // Frame is frozen until the consumer takes it.
        if (value_ready) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        value_d = '0;
        err_d   = '0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      value_q       <= '0;
      err_q         <= '0;
      sync_err_q    <= 1'b0;
      seg_ready_q   <= 1'b1;
      value_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      value_q       <= value_d;
      err_q         <= err_d;
      sync_err_q    <= sync_err_d;
      seg_ready_q   <= (state_d != DONE);
      value_valid_q <= (state_d == DONE);
    end
  end

  assign seg_ready   = seg_ready_q;
  assign value_valid = value_valid_q;
  assign value_out   = value_q;
  assign err_mask    = err_q;
  assign sync_err    = sync_err_q;

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, giving the number of hex digits per frame (legal range 1..8).
REQ-002 SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input seg_in, 7 bits: active-low segment pattern, bit0 = segment a through bit6 = segment g.
REQ-005 SHALL have input seg_valid, 1 bit: seg_in holds a digit.
REQ-006 SHALL have output seg_ready, 1 bit: block can accept a digit; a digit transfers when seg_valid and seg_ready are both high at a clock edge.
REQ-007 SHALL have input frame_start, 1 bit: qualified by seg_valid; marks the transferred digit as the most significant digit of a frame.
REQ-008 SHALL have output value_out, 4*NUM_DIGITS bits: decoded frame, first digit received in the top nibble.
REQ-009 SHALL have output value_valid, 1 bit: value_out and err_mask hold a complete frame.
REQ-010 SHALL have input value_ready, 1 bit: consumer accepts the frame when value_valid and value_ready are both high.
REQ-011 SHALL have output err_mask, NUM_DIGITS bits: bit i set = digit i (0 = first received) was not a legal pattern.
REQ-012 SHALL have output sync_err, 1 bit: one-cycle pulse when a frame is aborted by an early frame_start.

Function
REQ-013 SHALL decode per the legal-pattern table (hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-014 SHALL decode any other pattern to nibble 0 and set the matching err_mask bit.
REQ-015 SHALL implement states IDLE, COLLECT, DONE.
REQ-016 IDLE: seg_ready=1; a transfer with frame_start=1 stores digit 0, sets count=1 and goes to COLLECT (or to DONE if NUM_DIGITS=1); a transfer with frame_start=0 is discarded with no state change.
REQ-017 COLLECT: seg_ready=1; each transfer with frame_start=0 shifts the decoded nibble into value_out from the LSB end and increments count; on the transfer that makes count=NUM_DIGITS the state goes to DONE.
REQ-018 COLLECT: a transfer with frame_start=1 SHALL discard the partial frame, clear err_mask, pulse sync_err the next cycle, store the digit as digit 0, set count=1 and stay in COLLECT.
REQ-019 DONE: seg_ready=0 and value_valid=1; value_out and err_mask SHALL be held stable until value_ready=1, then the state goes to IDLE on that edge.
REQ-020 Latency: value_valid SHALL rise on the clock edge that transfers the last digit, so it is visible the cycle after that transfer.
REQ-021 seg_ready SHALL be a registered or pure state decode with no combinational dependence on seg_valid.
REQ-022 value_out SHALL be cleared to 0 when a new frame starts, so unused positions never carry stale data.
REQ-023 count SHALL be wide enough for NUM_DIGITS and SHALL never exceed NUM_DIGITS.

Reset
REQ-024 On reset high the block SHALL enter IDLE immediately with value_out=0, err_mask=0, value_valid=0, sync_err=0, count=0 and seg_ready=1.
REQ-025 Reset asserted mid-frame or in DONE SHALL drop the frame without emitting it; the first post-reset frame SHALL decode normally.

Verification
REQ-026 Frame 40,79,24,30,19,12 with frame_start on the first digit -> value_out=0x012345, err_mask=0, value_valid high one cycle after the 6th transfer.
REQ-027 Frame 08,03,46,21,06,7F -> value_out=0xABCDE0, err_mask=0b100000.
REQ-028 Three digits, then frame_start with 00, then 5 more 40s -> sync_err pulses once, value_out=0x800000.
REQ-029 Hold value_ready=0 for 10 cycles in DONE while seg_valid=1 -> seg_ready=0, value_out stable, no digits consumed; value_ready=1 -> IDLE next cycle.
REQ-030 Digits without frame_start in IDLE -> discarded, value_valid stays 0.
REQ-031 Reset pulse after 4 digits, then a full 0x012345 frame -> only 0x012345 is emitted.
